m_pipe_adder: RTL and testbench
===============================

# m_pipe_adder

Parametrised, pipelined two's-complement adder/subtractor for the datapath. Splits a WIDTH-bit add into STAGES equal ripple-carry slices, one slice per clock, with the carry registered between slices. Accepts one operation per cycle under a valid/ready handshake with full backpressure. Reports carry-out and signed overflow, so it replaces the single-cycle 32-bit ripple adder wherever timing is tight.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES
- STAGES, 4, pipeline depth and number of slices; slice width CW = WIDTH/STAGES, 1 <= STAGES <= WIDTH
- w_clk  input  1  clock, rising edge
- w_rst_n  input  1  reset, asynchronous, active-low
- w_in_valid  input  1  operands and mode present
- w_in_ready  output  1  block accepts an operation this cycle
- w_a  input  WIDTH  operand A
- w_b  input  WIDTH  operand B
- w_sub  input  1  0 = A+B, 1 = A-B
- w_out_valid  output  1  result present
- w_out_ready  input  1  consumer accepts the result
- w_s  output  WIDTH  result, modulo 2^WIDTH
- w_cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
- w_ovf  output  1  signed overflow

## Operation
- Input transfer when w_in_valid & w_in_ready; output transfer when w_out_valid & w_out_ready.
- Subtract = A + ~B + 1: B is inverted and carry-in is forced to 1 at slice 0 at acceptance.
- Stage k (0..STAGES-1) adds slice k of A and B with the carry registered by stage k-1 (stage 0 uses the mode carry-in).
- Unconsumed operand slices are carried forward in the stage registers. Finished result slices are delayed so that all slices of one operation emerge together.
- Each stage holds a valid bit. Global advance: adv = !valid[STAGES-1] | w_out_ready.
- When adv = 1, every stage loads from its predecessor, and stage 0 loads the input, with valid = w_in_valid.
- When adv = 0, all stages hold. No bubble squeezing.
- w_in_ready = adv. This is a combinational path from w_out_ready and is permitted.
- w_ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- w_s, w_cout and w_ovf are driven from the last stage's registers. They are stable while w_out_valid & !w_out_ready.
- Arithmetic is pure modulo 2^WIDTH: wrap-around is not saturated; it is flagged by w_cout and w_ovf only.

## Timing
- Latency: a result accepted at edge n appears with w_out_valid = 1 after edge n+STAGES-1, i.e. STAGES cycles of register delay when no stall occurs.
- Throughput: one operation per cycle while w_out_ready = 1.
- Full pipeline with w_out_ready = 0: w_in_ready = 0 in the same cycle, and nothing is accepted or lost.
- Simultaneous output and input transfer in one cycle is legal at full throughput.
- Reset (asynchronous assert, any time, including mid-stream): all valid bits 0, w_out_valid = 0, w_s = 0, w_cout = 0, w_ovf = 0, all slice and carry registers 0. In-flight operations are discarded.
- After reset deassert, w_in_ready = 1.
- Data registers that are not valid may hold don't-care values after reset only in the sense that they are masked by valid. They are nevertheless reset to 0 for deterministic simulation.

## Structure
- Shared package pipe_adder_pkg holds:
  - the mode encodings MODE_ADD = 0 and MODE_SUB = 1,
  - a function computing CW with a compile-time check that WIDTH % STAGES == 0.
- Sub-module m_pipe_slice, one CW-bit registered ripple slice with carry in/out, instantiated STAGES times by generate loop.
  - Inside each slice, the adder is a chain of full-adder cells.
- Top level holds the valid chain, the advance logic, the operand skew registers and the result alignment registers.

## Test plan
- WIDTH=32, STAGES=4: 321+4444 then 1024+2048 on consecutive cycles with w_out_ready=1 -> results 4765 and 3072 on consecutive cycles, first result 4 cycles after acceptance, cout=0, ovf=0.
- 0xFFFFFFFF + 0x00000001 -> s=0x00000000, cout=1, ovf=0; 0x7FFFFFFF + 1 -> s=0x80000000, cout=0, ovf=1.
- Subtract: 5-7 -> s=0xFFFFFFFE, cout=0, ovf=0; 0x80000000-1 -> s=0x7FFFFFFF, cout=1, ovf=1; 7-7 -> s=0, cout=1.
- Stream of 10 random operations, w_out_ready held 0 for 3 cycles mid-stream -> w_in_ready falls once the pipeline is full, output held stable, all 10 results correct, in order, with no duplicates.
- Assert w_rst_n low for 1 cycle with 3 operations in flight -> w_out_valid=0 and all outputs 0 immediately (asynchronous), no stale result emerges afterwards, next operation has normal latency.
- Re-run the first three scenarios with WIDTH=16, STAGES=1 and WIDTH=64, STAGES=8 -> latency equals STAGES and results match a reference model.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding and slice sizing.
package pipe_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Slice width; callers compare calc_cw(w, s) * s against w to reject uneven splits.
  function automatic int unsigned calc_cw(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

endpackage

// File: rtl/m_pipe_slice.sv
// One registered ripple-carry slice: CW full-adder cells, sum/carry/overflow captured on en.
module m_pipe_slice
  import pipe_adder_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          ovf
);

  logic [CW:0]   c;
  logic [CW-1:0] sum;

  assign c[0] = cin;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  // Overflow only matters in the most significant slice; the top picks that one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (en) begin
      s    <= sum;
      cout <= c[CW];
      ovf  <= c[CW] ^ c[CW-1];
    end
  end

endmodule

// File: rtl/m_pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES ripple slices, one per clock, valid/ready with stall-all backpressure.
module m_pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_in_valid,
  output logic             w_in_ready,
  input  logic [WIDTH-1:0] w_a,
  input  logic [WIDTH-1:0] w_b,
  input  logic             w_sub,
  output logic             w_out_valid,
  input  logic             w_out_ready,
  output logic [WIDTH-1:0] w_s,
  output logic             w_cout,
  output logic             w_ovf
);

  localparam int unsigned CW = calc_cw(WIDTH, STAGES);

  if (STAGES == 0 || STAGES > WIDTH || CW * STAGES != WIDTH) begin : g_cfg_err
    $error("m_pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic              adv;
  logic              sub_c;
  logic [WIDTH-1:0]  b_in;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] sl_c;
  logic [CW-1:0]     sl_s   [STAGES];
  logic              sl_ovf [STAGES];

  assign adv        = !valid_q[STAGES-1] || w_out_ready;
  assign w_in_ready = adv;
  assign sub_c      = (mode_e'(w_sub) == MODE_SUB);
  assign b_in       = sub_c ? ~w_b : w_b;

  // Valid chain: whole pipe moves together or holds together.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q[0] <= w_in_valid;
      for (int k = 1; k < int'(STAGES); k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned OPW = WIDTH - k * CW;
    localparam int unsigned RW  = (k + 1) * CW;

    // op_*: operand bits not yet consumed; res: finished low slices of this operation.
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    logic           cin;
    logic [RW-1:0]  res;

    if (k == 0) begin : g_head
      assign op_a = w_a;
      assign op_b = b_in;
      assign cin  = sub_c;
      assign res  = sl_s[0];
    end else begin : g_body
      logic [OPW-1:0]   a_q;
      logic [OPW-1:0]   b_q;
      logic [RW-CW-1:0] r_q;

      always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
        end else if (adv) begin
          a_q <= g_stage[k-1].op_a[OPW+CW-1:CW];
          b_q <= g_stage[k-1].op_b[OPW+CW-1:CW];
          r_q <= g_stage[k-1].res;
        end
      end

      assign op_a = a_q;
      assign op_b = b_q;
      assign cin  = sl_c[k-1];
      assign res  = {sl_s[k], r_q};
    end

    m_pipe_slice #(.CW(CW)) u_slice (
      .clk   (w_clk),
      .rst_n (w_rst_n),
      .en    (adv),
      .a     (op_a[CW-1:0]),
      .b     (op_b[CW-1:0]),
      .cin   (cin),
      .s     (sl_s[k]),
      .cout  (sl_c[k]),
      .ovf   (sl_ovf[k])
    );
  end

  assign w_out_valid = valid_q[STAGES-1];
  assign w_s         = g_stage[STAGES-1].res;
  assign w_cout      = sl_c[STAGES-1];
  assign w_ovf       = sl_ovf[STAGES-1];

endmodule

// File: tb/tb_m_pipe_adder.sv
// Scoreboard bench for m_pipe_adder at three WIDTH/STAGES configurations sharing one clock.
module tb_m_pipe_adder;

  logic clk;
  int   cyc;
  int   n_checks;
  int   n_fail;

  initial begin
    clk      = 1'b0;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int cfg, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d: got 0x%0h expected 0x%0h at cycle %0d", nm, cfg, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned W  = (g == 0) ? 32 : (g == 1) ? 16 : 64;
    localparam int unsigned S  = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    localparam int          SI = S;

    typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
      int           cyc;
      logic         lat;
    } exp_t;

    logic         rst_n, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, s;
    logic         saw_full;
    logic         fin;
    exp_t         q[$];

    m_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .w_clk       (clk),
      .w_rst_n     (rst_n),
      .w_in_valid  (in_valid),
      .w_in_ready  (in_ready),
      .w_a         (a),
      .w_b         (b),
      .w_sub       (sub),
      .w_out_valid (out_valid),
      .w_out_ready (out_ready),
      .w_s         (s),
      .w_cout      (cout),
      .w_ovf       (ovf)
    );

    // Reference: unsigned arithmetic for sum/carry, sign-extended arithmetic for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m, input logic lat);
      exp_t            e;
      logic [W:0]      u;
      logic signed [W:0] sv;
      if (m) begin
        u   = {1'b0, x} - {1'b0, y};
        e.c = (x >= y);
        sv  = $signed({x[W-1], x}) - $signed({y[W-1], y});
      end else begin
        u   = {1'b0, x} + {1'b0, y};
        e.c = u[W];
        sv  = $signed({x[W-1], x}) + $signed({y[W-1], y});
      end
      e.s   = u[W-1:0];
      e.v   = (sv[W] != sv[W-1]);
      e.cyc = cyc;
      e.lat = lat;
      return e;
    endfunction

    function automatic logic [W-1:0] rnd();
      return W'({$urandom(), $urandom()});
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                         input logic ordy, input logic lat, output logic acc);
      @(negedge clk);
      in_valid  = v;
      a         = x;
      b         = y;
      sub       = m;
      out_ready = ordy;
      #1;
      acc = v & in_ready;
      if (acc) q.push_back(model(x, y, m, lat));
    endtask

    task automatic drain();
      logic acc;
      int   t;
      t = 0;
      while (q.size() != 0 && t < 100) begin
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
        t++;
      end
      chk("drain_empty", g, 64'(q.size()), 64'(0));
    endtask

    // Monitor: pops on every output transfer and checks hold-stability during stalls.
    initial begin
      exp_t         e;
      logic         pstall, pc, pv;
      logic [W-1:0] ps;
      pstall = 1'b0;
      pc     = 1'b0;
      pv     = 1'b0;
      ps     = '0;
      forever begin
        @(negedge clk);
        #2;
        if (rst_n !== 1'b1) begin
          pstall = 1'b0;
        end else begin
          if (pstall) begin
            chk("hold_valid", g, 64'(out_valid), 64'(1));
            chk("hold_s", g, 64'(s), 64'(ps));
            chk("hold_flags", g, 64'({cout, ovf}), 64'({pc, pv}));
          end
          if (out_valid && out_ready) begin
            chk("result_pending", g, 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) begin
              e = q.pop_front();
              chk("sum", g, 64'(s), 64'(e.s));
              chk("cout", g, 64'(cout), 64'(e.c));
              chk("ovf", g, 64'(ovf), 64'(e.v));
              if (e.lat) chk("latency", g, 64'(cyc - e.cyc), 64'(SI));
            end
          end
          pstall = out_valid && !out_ready;
          if (pstall && !in_ready) saw_full = 1'b1;
          ps = s;
          pc = cout;
          pv = ovf;
        end
      end
    end

    // Stimulus: reset, directed corners, stalled random stream, mid-stream reset.
    initial begin
      logic         acc, m;
      logic [W-1:0] ones, maxp, x, y;
      logic [W-1:0] da [7];
      logic [W-1:0] db [7];
      logic         dm [7];
      int           nacc, j;

      fin       = 1'b0;
      saw_full  = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      out_ready = 1'b1;
      ones      = '1;
      maxp      = ones >> 1;
      #1;
      chk("rst_out_valid", g, 64'(out_valid), 64'(0));
      chk("rst_s", g, 64'(s), 64'(0));
      chk("rst_flags", g, 64'({cout, ovf}), 64'(0));
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      #1 chk("in_ready_after_rst", g, 64'(in_ready), 64'(1));

      da[0] = W'(321);  db[0] = W'(4444); dm[0] = 1'b0;
      da[1] = W'(1024); db[1] = W'(2048); dm[1] = 1'b0;
      da[2] = ones;     db[2] = W'(1);    dm[2] = 1'b0;
      da[3] = maxp;     db[3] = W'(1);    dm[3] = 1'b0;
      da[4] = W'(5);    db[4] = W'(7);    dm[4] = 1'b1;
      da[5] = ~maxp;    db[5] = W'(1);    dm[5] = 1'b1;
      da[6] = W'(7);    db[6] = W'(7);    dm[6] = 1'b1;
      for (int i = 0; i < 7; i++) begin
        drive(1'b1, da[i], db[i], dm[i], 1'b1, 1'b1, acc);
        chk("accept_directed", g, 64'(acc), 64'(1));
      end
      drain();

      nacc = 0;
      j    = 0;
      x    = rnd();
      y    = rnd();
      m    = 1'($urandom_range(0, 1));
      while (nacc < 10 && j < 200) begin
        drive(1'b1, x, y, m, !(j >= SI + 1 && j <= SI + 3), 1'b0, acc);
        if (acc) begin
          nacc++;
          x = rnd();
          y = rnd();
          m = 1'($urandom_range(0, 1));
        end
        j++;
      end
      chk("stream_accepted", g, 64'(nacc), 64'(10));
      drain();
      chk("in_ready_fell", g, 64'(saw_full), 64'(1));

      for (int i = 0; i < 3; i++) begin
        drive(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b1, 1'b0, acc);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_out_valid", g, 64'(out_valid), 64'(0));
      chk("midrst_s", g, 64'(s), 64'(0));
      chk("midrst_flags", g, 64'({cout, ovf}), 64'(0));
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1 chk("in_ready_after_midrst", g, 64'(in_ready), 64'(1));
      drive(1'b1, rnd(), rnd(), 1'b1, 1'b1, 1'b1, acc);
      chk("accept_after_rst", g, 64'(acc), 64'(1));
      drain();
      repeat (SI + 2) drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].fin === 1'b1 && g_cfg[1].fin === 1'b1 && g_cfg[2].fin === 1'b1) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("all_done", 0, 64'({g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin}), 64'(3'b111));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
